// File: rtl/udc_ctrl_pkg.sv
// Shared types and defaults for the UDC bus controller: host command opcodes,
// controller FSM states and the default nwr/nrd strobe width.
package udc_ctrl_pkg;

  localparam int STROBE_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_START   = 2'b10,
    OP_ILLEGAL = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_START  = 3'd4
  } state_t;

  // WRITE and READ are the only opcodes that run a chip-select bus cycle.
  function automatic logic is_bus_op(cmd_op_t op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/udc_evt_mon.sv
// UDC status monitor: counts rising edges of ec_o (wrapping 8-bit count) and
// keeps a sticky error flag fed by err_o, cleared by clr_err (set has priority).
module udc_evt_mon (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       ec_o,
  input  logic       err_o,
  input  logic       clr_err,
  output logic [7:0] ev_count,
  output logic       err_flag
);

  logic ec_prev_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ec_prev_q <= 1'b0;
      ev_count  <= 8'd0;
    end else begin
      ec_prev_q <= ec_o;
      if (ec_o && !ec_prev_q) begin
        ev_count <= ev_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      err_flag <= 1'b0;
    end else if (err_o) begin
      err_flag <= 1'b1;
    end else if (clr_err) begin
      err_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/udc_bus_ctrl.sv
// Host-command to UDC bus sequencer: runs WRITE/READ chip-select cycles with
// programmable strobe width, START pulses and illegal-op reporting.
//
// Handshake: cmd_valid/cmd_ready follow valid/ready semantics -- a command is
// taken on any rising edge where both are high; cmd_valid must hold its fields
// stable until then. rsp_valid is a single-cycle pulse with no back-pressure.
module udc_bus_ctrl
  import udc_ctrl_pkg::*;
#(
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       ncs,
  output logic       nwr,
  output logic       nrd,
  output logic       A0_i,
  output logic       A1_i,
  output logic       start_i,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in,
  input  logic       ec_o,
  input  logic       err_o,
  input  logic       clr_err,
  output logic [7:0] ev_count,
  output logic       err_flag,
  output logic [2:0] dbg_state
);

  state_t     state_q, state_d;
  cmd_op_t    op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       accept;
  logic       capture;

  logic bus_phase_d;
  logic ncs_d, nwr_d, nrd_d, d_oe_d, start_d;
  logic rsp_valid_d, rsp_err_d, cmd_ready_d;

  assign accept    = cmd_valid && cmd_ready && (state_q == ST_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_WRITE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus the output values that the next state will present; the
  // outputs are then registered so every pin comes straight from a flop.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = cmd_op_t'(cmd_op);
          state_d = is_bus_op(op_d) ? ST_SETUP : ST_START;
        end
      end
      ST_SETUP: begin
        state_d = ST_STROBE;
        cnt_d   = 4'(STROBE_CYCLES - 1);
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          capture = (op_q == OP_READ);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD:  state_d = ST_IDLE;
      ST_START: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    bus_phase_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    ncs_d       = !bus_phase_d;
    nwr_d       = !((state_d == ST_STROBE) && (op_d == OP_WRITE));
    nrd_d       = !((state_d == ST_STROBE) && (op_d == OP_READ));
    d_oe_d      = bus_phase_d && (op_d == OP_WRITE);
    start_d     = (state_d == ST_START) && (op_d == OP_START);
    rsp_valid_d = (state_d == ST_HOLD) || (state_d == ST_START);
    rsp_err_d   = (state_d == ST_START) && (op_d == OP_ILLEGAL);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      cmd_ready <= 1'b0;
      ncs       <= 1'b1;
      nwr       <= 1'b1;
      nrd       <= 1'b1;
      A0_i      <= 1'b0;
      A1_i      <= 1'b0;
      start_i   <= 1'b0;
      d_out     <= 8'd0;
      d_oe      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_ready <= cmd_ready_d;
      ncs       <= ncs_d;
      nwr       <= nwr_d;
      nrd       <= nrd_d;
      start_i   <= start_d;
      d_oe      <= d_oe_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      // Address and write data are latched once at accept and held for the
      // whole chip-select window; START/illegal leave the bus untouched.
      if (accept && is_bus_op(op_d)) begin
        A1_i <= cmd_addr[1];
        A0_i <= cmd_addr[0];
        if (op_d == OP_WRITE) begin
          d_out <= cmd_wdata;
        end
      end
      if (capture) begin
        rsp_rdata <= d_in;
      end
    end
  end

  udc_evt_mon u_evt_mon (
    .clk      (clk),
    .reset_i  (reset_i),
    .ec_o     (ec_o),
    .err_o    (err_o),
    .clr_err  (clr_err),
    .ev_count (ev_count),
    .err_flag (err_flag)
  );

  a_no_dual_strobe: assert property (@(posedge clk) disable iff (reset_i) !(!nwr && !nrd));
  a_strobe_in_cs:   assert property (@(posedge clk) disable iff (reset_i) ncs |-> (nwr && nrd));

endmodule
